// File: rtl/tile_match_core_pkg.sv
// ----------------------------------------------------------------------------
// tile_match_core_pkg : shared FSM encoding and default parameters
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package tile_match_core_pkg;

  localparam int unsigned N_TILES_DEF       = 10;
  localparam int unsigned SYM_W_DEF         = 4;
  localparam int unsigned REVEAL_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK1 = 3'd1,
    ST_PICK2 = 3'd2,
    ST_CHECK = 3'd3,
    ST_SHOW  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tile_match_core_if.sv
// ----------------------------------------------------------------------------
// tile_match_core_if : player controls and board status of the tile game
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface tile_match_core_if
  import tile_match_core_pkg::*;
#(
  parameter int N_TILES = N_TILES_DEF,
  parameter int SYM_W   = SYM_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  logic                       load;
  logic [N_TILES*SYM_W-1:0]   layout_in;
  logic [N_TILES-1:0]         sel;
  logic                       pick1;
  logic                       pick2;
  logic [N_TILES-1:0]         revealed;
  logic [N_TILES-1:0]         matched;
  logic [CNT_W-1:0]           score;
  logic [CNT_W-1:0]           tries;
  logic                       mismatch;
  logic                       err;
  logic                       done;

  modport master (
    output load, layout_in, sel, pick1, pick2,
    input  revealed, matched, score, tries, mismatch, err, done
  );

  modport slave (
    input  load, layout_in, sel, pick1, pick2,
    output revealed, matched, score, tries, mismatch, err, done
  );

endinterface

`default_nettype wire

// File: rtl/tile_match_core_edge_rise.sv
// ----------------------------------------------------------------------------
// edge_rise : single-register rising-edge detector
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

`default_nettype wire

// File: rtl/tile_match_core.sv
// ----------------------------------------------------------------------------
// tile_match_core : memory tile-matching game controller
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tile_match_core
  import tile_match_core_pkg::*;
#(
  parameter int N_TILES       = N_TILES_DEF,
  parameter int SYM_W         = SYM_W_DEF,
  parameter int REVEAL_CYCLES = REVEAL_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  tile_match_core_if.slave   bus
);

  localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam int TMR_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;

  state_e                   state_q, state_d;
  logic [N_TILES*SYM_W-1:0] layout_q, layout_d;
  logic [N_TILES-1:0]       matched_q, matched_d;
  logic [N_TILES-1:0]       revealed_q, revealed_d;
  logic [CNT_W-1:0]         score_q, score_d;
  logic [CNT_W-1:0]         tries_q, tries_d;
  logic [IDX_W-1:0]         idx1_q, idx1_d;
  logic [IDX_W-1:0]         idx2_q, idx2_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic                     mismatch_q, mismatch_d;
  logic                     err_q, err_d;

  logic [2:0]               w_raw, w_rise;
  logic                     w_load_rise, w_pick1_rise, w_pick2_rise;
  logic [IDX_W-1:0]         w_sel_idx;
  logic                     w_sel_onehot, w_sel_free;
  logic [SYM_W-1:0]         w_sym1, w_sym2;
  logic [N_TILES-1:0]       w_bit1, w_bit2;

  assign w_raw = {bus.pick2, bus.pick1, bus.load};

  for (genvar g = 0; g < 3; g++) begin : g_edge
    edge_rise u_edge (
      .clk    (CLOCK_50),
      .rst_n  (resetn),
      .d_i    (w_raw[g]),
      .rise_o (w_rise[g])
    );
  end

  assign w_load_rise  = w_rise[0];
  assign w_pick1_rise = w_rise[1];
  assign w_pick2_rise = w_rise[2];

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (bus.sel[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_sel_onehot = (bus.sel != '0) && ((bus.sel & (bus.sel - 1'b1)) == '0);
  assign w_sel_free   = (bus.sel & matched_q) == '0;
  assign w_sym1       = layout_q[int'(idx1_q)*SYM_W +: SYM_W];
  assign w_sym2       = layout_q[int'(idx2_q)*SYM_W +: SYM_W];
  assign w_bit1       = N_TILES'(1) << idx1_q;
  assign w_bit2       = N_TILES'(1) << idx2_q;

  always_comb begin
    state_d    = state_q;
    layout_d   = layout_q;
    matched_d  = matched_q;
    revealed_d = revealed_q;
    score_d    = score_q;
    tries_d    = tries_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    timer_d    = timer_q;
    mismatch_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Picks are not acted on here; a load always wins.
        if (w_load_rise) begin
          layout_d   = bus.layout_in;
          matched_d  = '0;
          revealed_d = '0;
          score_d    = '0;
          tries_d    = '0;
          state_d    = ST_PICK1;
        end
      end
      ST_PICK1: begin
        if (w_pick1_rise && !w_pick2_rise && w_sel_onehot && w_sel_free) begin
          idx1_d     = w_sel_idx;
          revealed_d = revealed_q | bus.sel;
          state_d    = ST_PICK2;
        end else if (w_pick1_rise || w_pick2_rise) begin
          err_d = 1'b1;
        end
      end
      ST_PICK2: begin
        if (w_pick2_rise && !w_pick1_rise && w_sel_onehot && w_sel_free &&
            (w_sel_idx != idx1_q)) begin
          idx2_d     = w_sel_idx;
          revealed_d = revealed_q | bus.sel;
          if (tries_q != '1) tries_d = tries_q + 1'b1;
          state_d    = ST_CHECK;
        end else if (w_pick1_rise || w_pick2_rise) begin
          err_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_sym1 == w_sym2) begin
          matched_d = matched_q | w_bit1 | w_bit2;
          if (score_q != '1) score_d = score_q + 1'b1;
          state_d   = (matched_d == '1) ? ST_DONE : ST_PICK1;
        end else begin
          mismatch_d = 1'b1;
          timer_d    = TMR_W'(REVEAL_CYCLES - 1);
          state_d    = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (w_pick1_rise || w_pick2_rise) err_d = 1'b1;
        if (timer_q == '0) begin
          revealed_d = revealed_q & ~(w_bit1 | w_bit2);
          state_d    = ST_PICK1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      layout_q   <= '0;
      matched_q  <= '0;
      revealed_q <= '0;
      score_q    <= '0;
      tries_q    <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      timer_q    <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      layout_q   <= layout_d;
      matched_q  <= matched_d;
      revealed_q <= revealed_d;
      score_q    <= score_d;
      tries_q    <= tries_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      timer_q    <= timer_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign bus.revealed = revealed_q;
  assign bus.matched  = matched_q;
  assign bus.score    = score_q;
  assign bus.tries    = tries_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err      = err_q;
  assign bus.done     = (state_q == ST_DONE);

endmodule

`default_nettype wire
